mii_rx_nibble_assembler: RTL and testbench



---
 rtl/mii_pkg.sv | 22 ++
 rtl/mii_rx_nibble_assembler.sv | 186 ++++++++++++++++++
 tb/tb_mii_rx_nibble_assembler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mii_pkg.sv
// Shared MII receive definitions: line-code nibbles, receiver states and
// helpers used by the nibble assembler.
package mii_pkg;

   localparam logic [3:0] PRE_NIBBLE = 4'h5;
   localparam logic [3:0] SFD_NIBBLE = 4'hD;

   localparam int DEFAULT_MAX_FRAME_BYTES = 1522;
   localparam int PRE_CNT_W               = 8;

   typedef enum logic [1:0] {
      DROP     = 2'd0,
      IDLE     = 2'd1,
      PREAMBLE = 2'd2,
      DATA     = 2'd3
   } rx_state_t;

   function automatic logic [PRE_CNT_W-1:0] sat_inc(input logic [PRE_CNT_W-1:0] v);
      sat_inc = (v == {PRE_CNT_W{1'b1}}) ? v : v + PRE_CNT_W'(1);
   endfunction

endpackage

// File: rtl/mii_rx_nibble_assembler.sv
// MII receive front end: strips preamble/SFD, packs nibble pairs into bytes
// and emits a registered byte stream with last/error/length marking.
module mii_rx_nibble_assembler
   import mii_pkg::*;
#(
   parameter int MIN_PREAMBLE_NIBBLES = 2,
   parameter int MAX_FRAME_BYTES      = DEFAULT_MAX_FRAME_BYTES,
   parameter int LEN_W                = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             phy_rx_dv,
   input  logic [3:0]       phy_rxd,
   input  logic             phy_rx_err,
   output logic [7:0]       rx_mac_data,
   output logic             rx_mac_valid,
   output logic             rx_mac_last,
   output logic             rx_mac_err,
   output logic [LEN_W-1:0] rx_frame_len
);

   rx_state_t            state_r, state_s;
   logic [PRE_CNT_W-1:0] pre_cnt_r, pre_cnt_s;
   logic                 phase_r, phase_s;
   logic [3:0]           low_r, low_s;
   logic [7:0]           hold_r, hold_s;
   logic                 hold_vld_r, hold_vld_s;
   logic [LEN_W-1:0]     byte_cnt_r, byte_cnt_s;
   logic                 err_seen_r, err_seen_s;

   logic [7:0]           data_r, data_s;
   logic                 valid_r, valid_s;
   logic                 last_r, last_s;
   logic                 err_r, err_s;
   logic [LEN_W-1:0]     len_r, len_s;

   // Next-state, packing and emission decisions.
   always_comb begin
      state_s    = state_r;
      pre_cnt_s  = pre_cnt_r;
      phase_s    = phase_r;
      low_s      = low_r;
      hold_s     = hold_r;
      hold_vld_s = hold_vld_r;
      byte_cnt_s = byte_cnt_r;
      err_seen_s = err_seen_r;
      data_s     = 8'h00;
      valid_s    = 1'b0;
      last_s     = 1'b0;
      err_s      = 1'b0;
      len_s      = {LEN_W{1'b0}};

      case (state_r)
         DROP: begin
            if (!phy_rx_dv) begin
               state_s = IDLE;
            end else begin
               state_s = DROP;
            end
         end

         IDLE: begin
            if (phy_rx_dv) begin
               if (phy_rxd == PRE_NIBBLE) begin
                  state_s   = PREAMBLE;
                  pre_cnt_s = PRE_CNT_W'(1);
               end else begin
                  state_s = DROP;
               end
            end else begin
               state_s = IDLE;
            end
         end

         PREAMBLE: begin
            if (!phy_rx_dv) begin
               state_s = IDLE;
            end else if (phy_rxd == PRE_NIBBLE) begin
               pre_cnt_s = sat_inc(pre_cnt_r);
            end else if ((phy_rxd == SFD_NIBBLE) &&
                         (pre_cnt_r >= PRE_CNT_W'(MIN_PREAMBLE_NIBBLES))) begin
               state_s    = DATA;
               phase_s    = 1'b0;
               byte_cnt_s = {LEN_W{1'b0}};
               err_seen_s = 1'b0;
               hold_vld_s = 1'b0;
            end else begin
               state_s = DROP;
            end
         end

         DATA: begin
            if (!phy_rx_dv) begin
               // End of frame: the held byte (if any) closes it; a dangling
               // low nibble marks the frame bad.
               state_s    = IDLE;
               phase_s    = 1'b0;
               hold_vld_s = 1'b0;
               if (hold_vld_r) begin
                  data_s  = hold_r;
                  valid_s = 1'b1;
                  last_s  = 1'b1;
                  err_s   = err_seen_r | phase_r;
                  len_s   = byte_cnt_r;
               end else begin
                  valid_s = 1'b0;
               end
            end else begin
               err_seen_s = err_seen_r | phy_rx_err;
               if (!phase_r) begin
                  low_s   = phy_rxd;
                  phase_s = 1'b1;
                  if (hold_vld_r && (byte_cnt_r == LEN_W'(MAX_FRAME_BYTES))) begin
                     data_s     = hold_r;
                     valid_s    = 1'b1;
                     last_s     = 1'b1;
                     err_s      = 1'b1;
                     len_s      = byte_cnt_r;
                     hold_vld_s = 1'b0;
                     state_s    = DROP;
                  end else begin
                     state_s = DATA;
                  end
               end else begin
                  // The previous byte is released only once its successor
                  // completes, so a trailing half nibble can still flag it.
                  hold_s     = {phy_rxd, low_r};
                  hold_vld_s = 1'b1;
                  byte_cnt_s = byte_cnt_r + LEN_W'(1);
                  phase_s    = 1'b0;
                  if (hold_vld_r) begin
                     data_s  = hold_r;
                     valid_s = 1'b1;
                  end else begin
                     valid_s = 1'b0;
                  end
               end
            end
         end

         default: begin
            state_s = DROP;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= DROP;
         pre_cnt_r  <= {PRE_CNT_W{1'b0}};
         phase_r    <= 1'b0;
         low_r      <= 4'h0;
         hold_r     <= 8'h00;
         hold_vld_r <= 1'b0;
         byte_cnt_r <= {LEN_W{1'b0}};
         err_seen_r <= 1'b0;
         data_r     <= 8'h00;
         valid_r    <= 1'b0;
         last_r     <= 1'b0;
         err_r      <= 1'b0;
         len_r      <= {LEN_W{1'b0}};
      end else begin
         state_r    <= state_s;
         pre_cnt_r  <= pre_cnt_s;
         phase_r    <= phase_s;
         low_r      <= low_s;
         hold_r     <= hold_s;
         hold_vld_r <= hold_vld_s;
         byte_cnt_r <= byte_cnt_s;
         err_seen_r <= err_seen_s;
         data_r     <= data_s;
         valid_r    <= valid_s;
         last_r     <= last_s;
         err_r      <= err_s;
         len_r      <= len_s;
      end
   end

   assign rx_mac_data  = data_r;
   assign rx_mac_valid = valid_r;
   assign rx_mac_last  = last_r;
   assign rx_mac_err   = err_r;
   assign rx_frame_len = len_r;

endmodule

// File: tb/tb_mii_rx_nibble_assembler.sv
// Scoreboard bench: two assemblers (default size limit and an 8-byte limit)
// share one MII stimulus stream; each has its own expectation queue.
module tb_mii_rx_nibble_assembler;

   logic       clk = 1'b0;
   logic       reset;
   logic       phy_rx_dv;
   logic [3:0] phy_rxd;
   logic       phy_rx_err;

   logic [7:0]  mac_data  [2];
   logic        mac_valid [2];
   logic        mac_last  [2];
   logic        mac_err   [2];
   logic [15:0] mac_len   [2];

   typedef struct {
      logic [7:0]  data;
      logic        last;
      logic        err;
      logic [15:0] len;
      int          cyc;
   } exp_t;

   exp_t       exp_q [2][$];
   logic [7:0] frame_q [$];
   int         n_chk  = 0;
   int         n_fail = 0;
   int         cyc    = 0;
   bit         mon_en = 1'b0;

   mii_rx_nibble_assembler dut_big (
      .clk(clk), .reset(reset), .phy_rx_dv(phy_rx_dv), .phy_rxd(phy_rxd),
      .phy_rx_err(phy_rx_err), .rx_mac_data(mac_data[0]),
      .rx_mac_valid(mac_valid[0]), .rx_mac_last(mac_last[0]),
      .rx_mac_err(mac_err[0]), .rx_frame_len(mac_len[0])
   );

   mii_rx_nibble_assembler #(.MAX_FRAME_BYTES(8)) dut_small (
      .clk(clk), .reset(reset), .phy_rx_dv(phy_rx_dv), .phy_rxd(phy_rxd),
      .phy_rx_err(phy_rx_err), .rx_mac_data(mac_data[1]),
      .rx_mac_valid(mac_valid[1]), .rx_mac_last(mac_last[1]),
      .rx_mac_err(mac_err[1]), .rx_frame_len(mac_len[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int k, input longint act, input longint req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s dut%0d @cyc %0d: actual %0h required %0h", name, k, cyc, act, req);
      end
   endtask

   task automatic mon(input int k);
      exp_t x;
      if (mac_valid[k]) begin
         if (exp_q[k].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_strobe dut%0d @cyc %0d: actual data %02h, required no strobe",
                     k, cyc, mac_data[k]);
         end else begin
            x = exp_q[k].pop_front();
            chk("data",   k, mac_data[k], x.data);
            chk("last",   k, mac_last[k], x.last);
            chk("err",    k, mac_err[k],  x.err);
            chk("len",    k, mac_len[k],  x.len);
            chk("timing", k, cyc,         x.cyc);
         end
      end else begin
         chk("idle_zero", k, {mac_last[k], mac_err[k], mac_len[k]}, 0);
      end
   endtask

   // Monitor: compares each presented byte against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 2; k++) mon(k);
      end
   end

   task automatic drive(input logic dv, input logic [3:0] d, input logic e, input logic r);
      @(negedge clk);
      phy_rx_dv  = dv;
      phy_rxd    = d;
      phy_rx_err = e;
      reset      = r;
   endtask

   // Sends preamble, SFD and frame_q (low nibble first), then drops dv.
   // n/ovs/e give, per DUT, the hand-derived byte count delivered, whether
   // it ends by oversize, and the error flag on the last byte.
   task automatic run_frame(input int pre_n, input bit dribble, input int err_step,
                            input int rst_step,
                            input int n0, input bit ovs0, input bit e0,
                            input int n1, input bit ovs1, input bit e1);
      logic [3:0] nib [$];
      int   nnib;
      int   n  [2];
      bit   ov [2];
      bit   ee [2];
      exp_t x;
      n[0] = n0; ov[0] = ovs0; ee[0] = e0;
      n[1] = n1; ov[1] = ovs1; ee[1] = e1;
      nib = {};
      foreach (frame_q[i]) begin
         nib.push_back(frame_q[i][3:0]);
         nib.push_back(frame_q[i][7:4]);
      end
      if (dribble) nib.push_back(4'h9);
      nnib = nib.size();
      for (int i = 0; i < pre_n; i++) drive(1'b1, 4'h5, 1'b0, 1'b0);
      drive(1'b1, 4'hD, 1'b0, 1'b0);
      for (int s = 0; s <= nnib; s++) begin
         if (s < nnib) drive(1'b1, nib[s], (s == err_step), (s == rst_step));
         else          drive(1'b0, 4'h0, 1'b0, 1'b0);
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < n[k]; i++) begin
               int trig;
               // A byte appears once the next byte completes, or at dv fall;
               // an oversize last appears on the next low nibble.
               if (ov[k] && i == n[k] - 1) trig = 2 * n[k];
               else if (2 * i + 3 < nnib)  trig = 2 * i + 3;
               else                        trig = nnib;
               if (trig == s) begin
                  x.data = frame_q[i];
                  x.last = (i == n[k] - 1);
                  x.err  = x.last & ee[k];
                  x.len  = x.last ? 16'(n[k]) : 16'd0;
                  x.cyc  = cyc + 1;
                  exp_q[k].push_back(x);
               end
            end
         end
      end
      repeat (3) drive(1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      reset      = 1'b1;
      phy_rx_dv  = 1'b0;
      phy_rxd    = 4'h0;
      phy_rx_err = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset_valid", k, mac_valid[k], 0);
         chk("reset_last",  k, mac_last[k],  0);
         chk("reset_err",   k, mac_err[k],   0);
         chk("reset_len",   k, mac_len[k],   0);
         chk("reset_data",  k, mac_data[k],  0);
      end
      mon_en = 1'b1;

      // Basic frame, 15 preamble nibbles.
      frame_q = '{8'h11, 8'h10, 8'h46, 8'hD1};
      run_frame(15, 1'b0, -1, -1, 4, 1'b0, 1'b0, 4, 1'b0, 1'b0);
      // Same frame, rx_err during the second byte.
      run_frame(15, 1'b0, 2, -1, 4, 1'b0, 1'b1, 4, 1'b0, 1'b1);
      // Three bytes plus a dribble nibble.
      frame_q = '{8'h21, 8'h43, 8'h65};
      run_frame(5, 1'b1, -1, -1, 3, 1'b0, 1'b1, 3, 1'b0, 1'b1);
      // Short preamble: payload that looks like preamble must be ignored.
      frame_q = '{8'h55, 8'hD5};
      run_frame(1, 1'b0, -1, -1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      // Minimum-length preamble accepted.
      frame_q = '{8'h7E, 8'h81};
      run_frame(2, 1'b0, -1, -1, 2, 1'b0, 1'b0, 2, 1'b0, 1'b0);
      // Empty frame and a single-nibble frame deliver nothing.
      frame_q = {};
      run_frame(3, 1'b0, -1, -1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run_frame(3, 1'b1, -1, -1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      // 12-byte frame: oversize only for the 8-byte-limit instance.
      frame_q = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56,
                  8'h67, 8'h78, 8'h89, 8'h9A, 8'hAB, 8'hBC};
      run_frame(7, 1'b0, -1, -1, 12, 1'b0, 1'b0, 8, 1'b1, 1'b1);
      frame_q = '{8'h01, 8'hFE};
      run_frame(7, 1'b0, -1, -1, 2, 1'b0, 1'b0, 2, 1'b0, 1'b0);
      // Reset mid-payload with dv held high.
      frame_q = '{8'hD5, 8'h55, 8'h5D};
      run_frame(7, 1'b0, -1, 2, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      frame_q = '{8'hA5, 8'h3C};
      run_frame(9, 1'b0, -1, -1, 2, 1'b0, 1'b0, 2, 1'b0, 1'b0);

      repeat (5) @(negedge clk);
      for (int k = 0; k < 2; k++) chk("drain", k, exp_q[k].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
